// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared core types: data width and architectural register
//               index/data typedefs used by the register file slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;
  localparam int XLEN         = 32;
  localparam int NUM_ARCH_REG = 32;
  localparam int ARCH_REG_W   = $clog2(NUM_ARCH_REG);

  typedef logic [ARCH_REG_W-1:0] arch_reg_t;
  typedef logic [XLEN-1:0]       xlen_t;
endpackage

`default_nettype wire

// File: rtl/arch_reg_file_mp_if.sv
// ============================================================================
// Module      : arch_reg_file_mp_if
// Description : Read, retire and checkpoint signal bundle for the
//               architectural register file. master = core side,
//               slave = register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface arch_reg_file_mp_if
  import riscv_pkg::*;
#(
  parameter int NUM_REG_LOG2 = ARCH_REG_W,
  parameter int REG_SIZE     = XLEN,
  parameter int NUM_READ     = 4,
  parameter int NUM_RETIRE   = 2
);
  logic [NUM_READ-1:0][NUM_REG_LOG2-1:0]   rd_idx;
  logic [NUM_READ-1:0][REG_SIZE-1:0]       rd_data;
  logic [NUM_RETIRE-1:0]                   ret_valid;
  logic [NUM_RETIRE-1:0][NUM_REG_LOG2-1:0] ret_reg;
  logic [NUM_RETIRE-1:0][REG_SIZE-1:0]     ret_data;
  logic                                    snap_req;
  logic                                    restore_req;
  logic                                    snap_valid;

  modport master (
    output rd_idx, ret_valid, ret_reg, ret_data, snap_req, restore_req,
    input  rd_data, snap_valid
  );

  modport slave (
    input  rd_idx, ret_valid, ret_reg, ret_data, snap_req, restore_req,
    output rd_data, snap_valid
  );
endinterface

`default_nettype wire

// File: rtl/arf_retire_merge.sv
// ============================================================================
// Module      : arf_retire_merge
// Description : Collapses all retire slots aimed at one register index into a
//               single write enable / data pair. The youngest (highest
//               numbered) matching slot wins; index 0 never produces a write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arf_retire_merge
  import riscv_pkg::*;
#(
  parameter int NUM_REG_LOG2 = ARCH_REG_W,
  parameter int REG_SIZE     = XLEN,
  parameter int NUM_RETIRE   = 2
) (
  input  logic [NUM_REG_LOG2-1:0]                 reg_idx_i,
  input  logic [NUM_RETIRE-1:0]                   ret_valid_i,
  input  logic [NUM_RETIRE-1:0][NUM_REG_LOG2-1:0] ret_reg_i,
  input  logic [NUM_RETIRE-1:0][REG_SIZE-1:0]     ret_data_i,
  output logic                                    we_o,
  output logic [REG_SIZE-1:0]                     wdata_o
);

  // Walk slots oldest to youngest so later matches override earlier ones.
  always_comb begin
    we_o    = 1'b0;
    wdata_o = '0;
    for (int s = 0; s < NUM_RETIRE; s++) begin
      if (ret_valid_i[s] && (ret_reg_i[s] == reg_idx_i) && (reg_idx_i != '0)) begin
        we_o    = 1'b1;
        wdata_o = ret_data_i[s];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/arch_reg_file_mp.sv
// ============================================================================
// Module      : arch_reg_file_mp
// Description : Multi-ported architectural register file with program-order
//               retire merging and a single shadow checkpoint. x0 reads zero.
//               Optional macro ARF_BYPASS_EN forwards same-cycle retire data
//               onto the read ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arch_reg_file_mp
  import riscv_pkg::*;
#(
  parameter int NUM_REG      = 32,
  parameter int NUM_REG_LOG2 = $clog2(NUM_REG),
  parameter int REG_SIZE     = XLEN,
  parameter int NUM_READ     = 4,
  parameter int NUM_RETIRE   = 2
) (
  input  logic               clk,
  input  logic               rst,
  arch_reg_file_mp_if.slave  bus
);

  logic [REG_SIZE-1:0] arf_q    [NUM_REG];
  logic [REG_SIZE-1:0] arf_d    [NUM_REG];
  logic [REG_SIZE-1:0] shadow_q [NUM_REG];
  logic                snap_valid_q;
  logic                snap_valid_d;

  logic [NUM_REG-1:0]  w_we;
  logic [REG_SIZE-1:0] w_wdata [NUM_REG];
  logic                w_restore;
  logic                w_snap;

  // A restore only counts when there is something to restore; a snapshot is
  // blocked by any restore request, effective or not.
  assign w_restore = bus.restore_req & snap_valid_q;
  assign w_snap    = bus.snap_req & ~bus.restore_req;

  generate
    for (genvar r = 0; r < NUM_REG; r++) begin : g_reg
      localparam logic [NUM_REG_LOG2-1:0] c_idx = NUM_REG_LOG2'(r);
      arf_retire_merge #(
        .NUM_REG_LOG2 (NUM_REG_LOG2),
        .REG_SIZE     (REG_SIZE),
        .NUM_RETIRE   (NUM_RETIRE)
      ) u_merge (
        .reg_idx_i   (c_idx),
        .ret_valid_i (bus.ret_valid),
        .ret_reg_i   (bus.ret_reg),
        .ret_data_i  (bus.ret_data),
        .we_o        (w_we[r]),
        .wdata_o     (w_wdata[r])
      );
    end
  endgenerate

  // Next architectural state: restore replaces the whole array and drops
  // retires, otherwise merged retire writes update individual entries.
  always_comb begin
    for (int r = 0; r < NUM_REG; r++) begin
      arf_d[r] = arf_q[r];
      if (w_restore) begin
        arf_d[r] = shadow_q[r];
      end else if (w_we[r]) begin
        arf_d[r] = w_wdata[r];
      end
    end
    arf_d[0] = '0;

    snap_valid_d = snap_valid_q;
    if (w_restore) begin
      snap_valid_d = 1'b0;
    end else if (w_snap) begin
      snap_valid_d = 1'b1;
    end
  end

  // State registers; the shadow captures post-retire values of the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REG; r++) begin
        arf_q[r]    <= '0;
        shadow_q[r] <= '0;
      end
      snap_valid_q <= 1'b0;
    end else begin
      arf_q        <= arf_d;
      snap_valid_q <= snap_valid_d;
      if (w_snap) begin
        shadow_q <= arf_d;
      end
    end
  end

  assign bus.snap_valid = snap_valid_q;

  generate
    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
      logic [REG_SIZE-1:0] w_arr;
      assign w_arr = (bus.rd_idx[p] == '0) ? '0 : arf_q[bus.rd_idx[p]];
`ifdef ARF_BYPASS_EN
      logic                w_byp_we;
      logic [REG_SIZE-1:0] w_byp_data;
      arf_retire_merge #(
        .NUM_REG_LOG2 (NUM_REG_LOG2),
        .REG_SIZE     (REG_SIZE),
        .NUM_RETIRE   (NUM_RETIRE)
      ) u_byp (
        .reg_idx_i   (bus.rd_idx[p]),
        .ret_valid_i (bus.ret_valid),
        .ret_reg_i   (bus.ret_reg),
        .ret_data_i  (bus.ret_data),
        .we_o        (w_byp_we),
        .wdata_o     (w_byp_data)
      );
      // Forwarding is only meaningful when the retire will actually land.
      assign bus.rd_data[p] = (w_byp_we && !rst && !w_restore) ? w_byp_data : w_arr;
`else
      assign bus.rd_data[p] = w_arr;
`endif
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_arch_reg_file_mp.sv
// ============================================================================
// Module      : tb_arch_reg_file_mp
// Description : Self-checking bench for arch_reg_file_mp with an array-based
//               reference model of the register file and checkpoint.
//               Honors ARF_BYPASS_EN when compiled with it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arch_reg_file_mp;
  import riscv_pkg::*;

  localparam int NREG = 32;
  localparam int NRD  = 4;
  localparam int NRT  = 2;
  localparam int W    = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arch_reg_file_mp_if #(.NUM_REG_LOG2(5), .REG_SIZE(W), .NUM_READ(NRD), .NUM_RETIRE(NRT)) bus ();

  arch_reg_file_mp #(
    .NUM_REG(NREG), .NUM_REG_LOG2(5), .REG_SIZE(W), .NUM_READ(NRD), .NUM_RETIRE(NRT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] m_arf    [NREG];
  logic [W-1:0] m_shadow [NREG];
  bit           m_sv;
  int errors = 0;
  int checks = 0;

  // Expected read-port value from the model plus current-cycle inputs.
  function automatic logic [W-1:0] exp_rd(int idx);
    logic [W-1:0] v;
    v = m_arf[idx];
    if (idx == 0) return '0;
`ifdef ARF_BYPASS_EN
    if (!rst && !(bus.restore_req && m_sv))
      for (int s = 0; s < NRT; s++)
        if (bus.ret_valid[s] && int'(bus.ret_reg[s]) == idx) v = bus.ret_data[s];
`endif
    return v;
  endfunction

  // Advance one clock edge and apply the architectural rules to the model.
  task automatic tick();
    logic [W-1:0] nxt [NREG];
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_arf[r] = '0;
        m_shadow[r] = '0;
      end
      m_sv = 1'b0;
    end else if (bus.restore_req && m_sv) begin
      m_arf = m_shadow;
      m_sv  = 1'b0;
    end else begin
      nxt = m_arf;
      for (int s = 0; s < NRT; s++)
        if (bus.ret_valid[s] && bus.ret_reg[s] != 0) nxt[bus.ret_reg[s]] = bus.ret_data[s];
      m_arf = nxt;
      if (bus.snap_req && !bus.restore_req) begin
        m_shadow = m_arf;
        m_sv = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle();
    bus.ret_valid   = '0;
    bus.ret_reg     = '0;
    bus.ret_data    = '0;
    bus.snap_req    = 1'b0;
    bus.restore_req = 1'b0;
    bus.rd_idx      = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.ret_valid = 2'b11;
    bus.ret_reg[0] = 5'd3;  bus.ret_data[0] = $urandom;
    bus.ret_reg[1] = 5'd9;  bus.ret_data[1] = $urandom;
    bus.snap_req = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    idle();
    for (int g = 0; g < NREG / NRD; g++) begin
      for (int p = 0; p < NRD; p++) bus.rd_idx[p] = 5'(g * NRD + p);
      #1;
      for (int p = 0; p < NRD; p++) begin
        checks++;
        if (bus.rd_data[p] !== '0) begin
          errors++;
          $display("FAIL reset_rd idx=%0d got=%h exp=0", g * NRD + p, bus.rd_data[p]);
        end
      end
    end
    checks++;
    if (bus.snap_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_snap_valid got=%b exp=0", bus.snap_valid);
    end
  endtask

  task automatic test_collision();
    idle();
    bus.ret_valid = 2'b11;
    bus.ret_reg[0] = 5'd5; bus.ret_data[0] = 32'hAAAA0000;
    bus.ret_reg[1] = 5'd5; bus.ret_data[1] = 32'h5555FFFF;
    tick();
    idle();
    bus.rd_idx[0] = 5'd5;
    #1;
    checks++;
    if (bus.rd_data[0] !== 32'h5555FFFF) begin
      errors++;
      $display("FAIL collision_x5 got=%h exp=%h", bus.rd_data[0], 32'h5555FFFF);
    end
  endtask

  task automatic test_x0();
    idle();
    for (int r = 1; r < NREG; r++) begin
      bus.ret_valid = 2'b01;
      bus.ret_reg[0] = 5'(r);
      bus.ret_data[0] = $urandom;
      tick();
    end
    idle();
    bus.ret_valid = 2'b01;
    bus.ret_reg[0] = 5'd0;
    bus.ret_data[0] = 32'hDEADBEEF;
    tick();
    idle();
    for (int r = 0; r < NREG; r++) begin
      bus.rd_idx[0] = 5'(r);
      #1;
      checks++;
      if (bus.rd_data[0] !== ((r == 0) ? 32'h0 : m_arf[r])) begin
        errors++;
        $display("FAIL x0_write idx=%0d got=%h exp=%h", r, bus.rd_data[0], (r == 0) ? 32'h0 : m_arf[r]);
      end
    end
  endtask

  task automatic test_snapshot_restore();
    idle();
    bus.ret_valid = 2'b01; bus.ret_reg[0] = 5'd3; bus.ret_data[0] = 32'd7;
    tick();
    bus.ret_data[0] = 32'd9; bus.snap_req = 1'b1;
    tick();
    idle();
    #1;
    checks++;
    if (bus.snap_valid !== 1'b1) begin
      errors++;
      $display("FAIL snap_valid_set got=%b exp=1", bus.snap_valid);
    end
    bus.ret_valid = 2'b01; bus.ret_reg[0] = 5'd3; bus.ret_data[0] = 32'd11;
    tick();
    idle();
    bus.restore_req = 1'b1;
    tick();
    idle();
    bus.rd_idx[1] = 5'd3;
    #1;
    checks++;
    if (bus.rd_data[1] !== 32'd9) begin
      errors++;
      $display("FAIL restore_x3 got=%h exp=%h", bus.rd_data[1], 32'd9);
    end
    checks++;
    if (bus.snap_valid !== 1'b0) begin
      errors++;
      $display("FAIL restore_snap_valid got=%b exp=0", bus.snap_valid);
    end
  endtask

  task automatic test_restore_noop();
    logic [W-1:0] keep6;
    idle();
    bus.restore_req = 1'b1;
    bus.ret_valid = 2'b01; bus.ret_reg[0] = 5'd4; bus.ret_data[0] = 32'h1234;
    tick();
    idle();
    bus.rd_idx[3] = 5'd4;
    #1;
    checks++;
    if (bus.rd_data[3] !== 32'h1234) begin
      errors++;
      $display("FAIL noop_restore_x4 got=%h exp=%h", bus.rd_data[3], 32'h1234);
    end
    checks++;
    if (bus.snap_valid !== 1'b0) begin
      errors++;
      $display("FAIL noop_restore_snap_valid got=%b exp=0", bus.snap_valid);
    end
    bus.snap_req = 1'b1;
    tick();
    idle();
    keep6 = m_arf[6];
    bus.snap_req = 1'b1; bus.restore_req = 1'b1;
    bus.ret_valid = 2'b10; bus.ret_reg[1] = 5'd6; bus.ret_data[1] = 32'h777;
    tick();
    idle();
    bus.rd_idx[2] = 5'd6;
    #1;
    checks++;
    if (bus.snap_valid !== 1'b0) begin
      errors++;
      $display("FAIL snap_and_restore_snap_valid got=%b exp=0", bus.snap_valid);
    end
    checks++;
    if (bus.rd_data[2] !== keep6) begin
      errors++;
      $display("FAIL snap_and_restore_x6 got=%h exp=%h", bus.rd_data[2], keep6);
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] expv;
    idle();
    bus.ret_valid = 2'b01; bus.ret_reg[0] = 5'd8; bus.ret_data[0] = 32'h11111111;
    tick();
    idle();
    bus.rd_idx[2] = 5'd8;
    bus.ret_valid = 2'b11;
    bus.ret_reg[0] = 5'd8; bus.ret_data[0] = 32'hBADBAD00;
    bus.ret_reg[1] = 5'd8; bus.ret_data[1] = 32'hCAFEF00D;
    #1;
`ifdef ARF_BYPASS_EN
    expv = 32'hCAFEF00D;
`else
    expv = 32'h11111111;
`endif
    checks++;
    if (bus.rd_data[2] !== expv) begin
      errors++;
      $display("FAIL bypass_same_cycle got=%h exp=%h", bus.rd_data[2], expv);
    end
    tick();
    idle();
    bus.rd_idx[2] = 5'd8;
    #1;
    checks++;
    if (bus.rd_data[2] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL bypass_next_cycle got=%h exp=%h", bus.rd_data[2], 32'hCAFEF00D);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int s = 0; s < NRT; s++) begin
        bus.ret_valid[s] = $urandom_range(0, 3) != 0;
        bus.ret_reg[s]   = ($urandom_range(0, 3) == 0) ? 5'(bus.ret_reg[0]) : 5'($urandom_range(0, NREG - 1));
        bus.ret_data[s]  = $urandom;
      end
      bus.snap_req    = $urandom_range(0, 5) == 0;
      bus.restore_req = $urandom_range(0, 7) == 0;
      for (int p = 0; p < NRD; p++)
        bus.rd_idx[p] = ($urandom_range(0, 1) == 0) ? 5'(bus.ret_reg[$urandom_range(0, NRT - 1)])
                                                   : 5'($urandom_range(0, NREG - 1));
      #1;
      for (int p = 0; p < NRD; p++) begin
        e = exp_rd(int'(bus.rd_idx[p]));
        checks++;
        if (bus.rd_data[p] !== e) begin
          errors++;
          $display("FAIL random_rd it=%0d port=%0d idx=%0d got=%h exp=%h", i, p, bus.rd_idx[p], bus.rd_data[p], e);
        end
      end
      checks++;
      if (bus.snap_valid !== m_sv) begin
        errors++;
        $display("FAIL random_snap_valid it=%0d got=%b exp=%b", i, bus.snap_valid, m_sv);
      end
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_collision();
    test_x0();
    test_snapshot_restore();
    test_restore_noop();
    test_bypass();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/arch_reg_file_mp.md
# arch_reg_file_mp

Multi-ported, checkpointable architectural register file for the out-of-order core's retire stage. Supports NUM_READ combinational read ports for rename/dispatch and NUM_RETIRE retire write ports per cycle, with program-order collision resolution. A single shadow checkpoint can be captured and restored for precise-state recovery. x0 is hardwired to zero.

## Interface
- NUM_REG, 32, number of architectural registers; power of two, at least 2
- NUM_REG_LOG2, $clog2(NUM_REG), register index width
- REG_SIZE, 32, register data width
- NUM_READ, 4, number of read ports; at least 1
- NUM_RETIRE, 2, number of retire write slots; slot 0 is oldest in program order
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rd_idx  in  NUM_READ×NUM_REG_LOG2  read port indices
- rd_data  out  NUM_READ×REG_SIZE  read port data
- ret_valid  in  NUM_RETIRE  per-slot retire strobe
- ret_reg  in  NUM_RETIRE×NUM_REG_LOG2  per-slot destination index
- ret_data  in  NUM_RETIRE×REG_SIZE  per-slot write data
- snap_req  in  1  capture checkpoint at this edge
- restore_req  in  1  restore checkpoint at this edge
- snap_valid  out  1  checkpoint holds captured state

## Operation
- Reads are combinational: rd_data[p] = arf[rd_idx[p]]. Index 0 always reads 0.
- Retire: for each register r ≠ 0, the highest-numbered slot s with ret_valid[s] && ret_reg[s]==r writes ret_data[s]. Later slots override earlier ones (program order). Slots targeting x0 are ignored.
- Snapshot: when snap_req is set and restore_req is clear, shadow[r] <= the post-retire value of r from the same edge, so retires in that cycle are included. snap_valid <= 1.
- Restore: when restore_req is set and snap_valid is 1, arf <= shadow and snap_valid <= 0. All ret_valid slots in that cycle are dropped.
- Restore with snap_valid == 0 is a no-op; retires in that cycle proceed normally.
- snap_req and restore_req in the same cycle: restore takes effect, snap is ignored, and snap_valid ends at 0. If snap_valid was 0, neither request takes effect and retires proceed.
- A snapshot while snap_valid is already 1 overwrites the existing shadow.

## Timing
- Reset: every arf entry is 0, every shadow entry is 0, and snap_valid is 0 at the first edge with rst high. rst overrides retire, snap and restore.
- Reset mid-operation discards any pending retire or snapshot; there is no partial state.
- Read latency is 0 cycles. Write-to-read latency is 1 cycle without the bypass.
- Restore latency is 1 cycle. Restored values are readable the cycle after the edge on which restore_req is seen.
- snap_valid changes only on clock edges.
- There is no backpressure: all retire slots are accepted every cycle except during reset or an effective restore.

## Configuration
- ARF_BYPASS_EN defined: each read port forwards same-cycle retire data.
  - rd_data[p] takes ret_data from the highest slot writing rd_idx[p] (x0 excluded).
  - Otherwise the port returns the array value.
  - Bypass is suppressed while rst is high or an effective restore is in progress; the port then returns the array value.
- ARF_BYPASS_EN undefined: reads return only the registered array contents.

## Structure
- Shared package riscv_pkg holds:
  - the XLEN constant (drives REG_SIZE)
  - typedef arch_reg_t for the register index
  - typedef xlen_t for register data
- Sub-module arf_retire_merge, one instance per register:
  - Resolves multi-slot writes for that register into a single write-enable and write-data pair, using the last-slot-wins rule.
  - The bypass path reuses the same priority logic.

## Test plan
- Reset, then read all 32 indices on 4 ports -> every rd_data is 0 and snap_valid is 0.
- Slot0 writes x5 = 0xAAAA0000 and slot1 writes x5 = 0x5555FFFF in the same cycle -> x5 reads 0x5555FFFF the next cycle.
- Slot0 writes x0 = 0xDEADBEEF -> x0 reads 0 and no other register changes.
- Write x3 = 7, then snap_req together with a slot0 retire x3 = 9, then write x3 = 11, then restore_req -> x3 reads 9 the cycle after restore and snap_valid is 0.
- restore_req with snap_valid = 0 while slot0 writes x4 = 0x1234 -> x4 reads 0x1234 and snap_valid stays 0. Same-cycle snap_req and restore_req with snap_valid = 1 -> restore occurs and snap_valid = 0.
- ARF_BYPASS_EN defined: rd_idx[2] = 8 while slot1 writes x8 = 0xCAFEF00D -> rd_data[2] shows 0xCAFEF00D in the same cycle. With the macro undefined -> rd_data[2] shows the old value until the next cycle.
